// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine feeding one HI/LO write port.
// Multiplies finish after MUL_STAGES cycles; divides use 32 restoring iterations.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on accept
//   MUL   | multiply latency padding (down-counter)
//   DIV   | one restoring-division iteration per cycle
//   DONE  | single-cycle HI/LO write, results already registered
module mul_div_unit #(
    parameter int MUL_STAGES = 2,
    parameter int DIV_ITER   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic        hilo_w_en,
    output logic [31:0] hi_w_data,
    output logic [31:0] lo_w_data
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic        signed_q;
    logic        div_zero_q;
    logic [31:0] a_q, b_q;
    logic [31:0] dvd_q, dvs_q, rem_q;
    logic        accept;
    logic        last_cnt;

    logic [31:0] mul_a, mul_b;
    logic        mul_signed;
    logic [63:0] ext_a, ext_b, product;

    logic [32:0] shifted;
    logic        rem_ge;
    logic [31:0] rem_sub, rem_nxt, quo_nxt;
    logic [31:0] quo_fix, rem_fix, div_hi, div_lo;

    assign accept   = (state == IDLE) && start && !cancel;
    assign last_cnt = (cnt == 6'd1);

    // With MUL_STAGES == 1 the product is taken straight from the live inputs.
    always_comb begin
        mul_a      = a_q;
        mul_b      = b_q;
        mul_signed = signed_q;
        if (state == IDLE) begin
            mul_a      = src_a;
            mul_b      = src_b;
            mul_signed = ~op[0];
        end
    end

    assign ext_a   = {{32{mul_signed & mul_a[31]}}, mul_a};
    assign ext_b   = {{32{mul_signed & mul_b[31]}}, mul_b};
    assign product = ext_a * ext_b;

    assign shifted = {rem_q, dvd_q[31]};
    assign rem_ge  = shifted >= {1'b0, dvs_q};
    assign rem_sub = {rem_q[30:0], dvd_q[31]} - dvs_q;
    assign rem_nxt = rem_ge ? rem_sub : shifted[31:0];
    assign quo_nxt = {dvd_q[30:0], rem_ge};

    // Sign fix-up on the final iteration so the DONE cycle sees registered results.
    assign quo_fix = (signed_q & (a_q[31] ^ b_q[31])) ? -quo_nxt : quo_nxt;
    assign rem_fix = (signed_q & a_q[31]) ? -rem_nxt : rem_nxt;
    assign div_hi  = div_zero_q ? a_q : rem_fix;
    assign div_lo  = div_zero_q ? 32'hFFFF_FFFF : quo_fix;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (op[1])
                        state_nxt = DIV;
                    else if (MUL_STAGES == 1)
                        state_nxt = DONE;
                    else
                        state_nxt = MUL;
                end
            end
            MUL, DIV: begin
                if (cancel)
                    state_nxt = IDLE;
                else if (last_cnt)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            signed_q   <= 1'b0;
            div_zero_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            hi_w_data  <= '0;
            lo_w_data  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q        <= src_a;
                b_q        <= src_b;
                signed_q   <= ~op[0];
                div_zero_q <= (src_b == 32'd0);
                dvd_q      <= (~op[0] & src_a[31]) ? -src_a : src_a;
                dvs_q      <= (~op[0] & src_b[31]) ? -src_b : src_b;
                rem_q      <= '0;
                cnt        <= op[1] ? 6'(DIV_ITER) : 6'(MUL_STAGES - 1);
            end else if (state == MUL || state == DIV) begin
                cnt <= cnt - 6'd1;
            end
            if (state == DIV) begin
                rem_q <= rem_nxt;
                dvd_q <= quo_nxt;
            end
            if (state_nxt == DONE) begin
                if (state == DIV) begin
                    hi_w_data <= div_hi;
                    lo_w_data <= div_lo;
                end else begin
                    hi_w_data <= product[63:32];
                    lo_w_data <= product[31:0];
                end
            end
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE) && !cancel;
    assign hilo_w_en = done;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table, scoreboard queue, and
// hand-written cancel / reset sequences.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        cancel;
    logic        busy, done, hilo_w_en;
    logic [31:0] hi_w_data, lo_w_data;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [63:0] sb_q[$];

    mul_div_unit #(.MUL_STAGES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .cancel(cancel),
        .busy(busy), .done(done), .hilo_w_en(hilo_w_en),
        .hi_w_data(hi_w_data), .lo_w_data(lo_w_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called 1 time unit after the edge that sampled start (T0).
    task automatic wait_done(input string name, input int elat, input bit noise);
        int seen;
        logic [63:0] exp;
        seen = 0;
        for (int k = 1; k <= 60 && seen == 0; k++) begin
            @(negedge clk);
            if (k == 1) check({name, " busy_t1"}, busy, 1'b1);
            if (done === 1'b1) begin
                seen  = k;
                start = 1'b0;
                check({name, " latency"}, k, elat);
                check({name, " hilo_w_en"}, hilo_w_en, 1'b1);
                check({name, " busy_done"}, busy, 1'b1);
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL %s: done with empty scoreboard", name);
                end else begin
                    exp = sb_q.pop_front();
                    check({name, " hi"}, hi_w_data, exp[63:32]);
                    check({name, " lo"}, lo_w_data, exp[31:0]);
                end
            end else if (noise) begin
                start = 1'($urandom_range(0, 1));
                op    = 2'($urandom_range(0, 3));
                src_a = $urandom;
                src_b = $urandom;
            end
        end
        if (seen == 0) begin
            total++; bad++;
            $display("FAIL %s: timeout waiting for done", name);
        end
        start = 1'b0;
        @(negedge clk);
        check({name, " pulse_end"}, done, 1'b0);
        check({name, " busy_end"}, busy, 1'b0);
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dc0;

        vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 2};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2};
        vecs[2]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2};
        vecs[3]  = '{2'b01, 32'h1234_5678, 32'd16,        32'h0000_0001, 32'h2345_6780, 2};
        vecs[4]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 33};
        vecs[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
        vecs[7]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
        vecs[8]  = '{2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 33};
        vecs[9]  = '{2'b11, 32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999, 33};
        vecs[10] = '{2'b11, 32'd5,         32'd9,         32'd5,         32'd0,         33};
        vecs[11] = '{2'b10, 32'h8000_0000, 32'd1,         32'd0,         32'h8000_0000, 33};

        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst hilo_w_en", hilo_w_en, 1'b0);
        check("rst hi", hi_w_data, 32'd0);
        check("rst lo", lo_w_data, 32'd0);

        // Table vectors with input noise (including start) while busy.
        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            sb_q.push_back({vecs[i].hi, vecs[i].lo});
            dc0 = done_cnt;
            wait_done($sformatf("vec%0d", i), vecs[i].lat, 1'b1);
            #1;
            check($sformatf("vec%0d done_count", i), done_cnt, dc0 + 1);
        end

        // Cancel mid-divide at T0+10, MULTU launched at T0+11.
        launch(2'b10, 32'd100, 32'd7);
        start = 1'b0;
        dc0 = done_cnt;
        repeat (9) @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel busy_t11", busy, 1'b0);
        start = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd5;
        sb_q.push_back({32'd0, 32'd15});
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("cancel_mulu", 2, 1'b0);
        repeat (30) @(negedge clk);
        #1;
        check("cancel done_count", done_cnt, dc0 + 1);

        // Cancel during the DONE cycle suppresses the write strobe.
        launch(2'b01, 32'd2, 32'd2);
        start = 1'b0;
        dc0 = done_cnt;
        @(posedge clk);
        #1 cancel = 1'b1;
        #1;
        check("cancel_done busy", busy, 1'b1);
        check("cancel_done done", done, 1'b0);
        check("cancel_done hilo_w_en", hilo_w_en, 1'b0);
        @(posedge clk);
        #1 cancel = 1'b0;
        check("cancel_done busy_after", busy, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("cancel_done done_count", done_cnt, dc0);

        // Asynchronous reset mid-divide: outputs clear at once, no write later.
        launch(2'b11, 32'd1000, 32'd3);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst busy", busy, 1'b0);
        check("arst done", done, 1'b0);
        check("arst hilo_w_en", hilo_w_en, 1'b0);
        check("arst hi", hi_w_data, 32'd0);
        check("arst lo", lo_w_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dc0 = done_cnt;
        repeat (40) @(negedge clk);
        #1;
        check("arst done_count", done_cnt, dc0);

        launch(2'b00, 32'd6, 32'hFFFF_FFFE);
        sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF4});
        wait_done("post_reset_mult", 2, 1'b1);

        check("scoreboard empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
